// File: rtl/mem_pkg.sv
// Shared widths and adapter state type for the word-to-byte memory adapter.
package mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_HI = 3'd1,
    WR_LO = 3'd2,
    RD_HI = 3'd3,
    RD_LO = 3'd4,
    RSP   = 3'd5
  } adapterState_t;

endpackage

// File: rtl/mem_word_adapter.sv
// Splits 16-bit word requests into two big-endian byte accesses on a
// byte-wide memory with a fixed read latency.
module mem_word_adapter
  import mem_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic              reqWrite,
  input  logic [ADDR_W-1:0] reqAddress,
  input  logic [WORD_W-1:0] reqWriteData,
  output logic              rspValid,
  output logic [WORD_W-1:0] rspReadData,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memAddress,
  output logic [BYTE_W-1:0] memWriteValue,
  input  logic [BYTE_W-1:0] memReadValue
);

  localparam logic [CNT_W-1:0] PHASE_LOAD = CNT_W'(READ_LATENCY);

  adapterState_t     state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [ADDR_W-1:0] addrReg, addrNext;
  logic [BYTE_W-1:0] loByteReg, loByteNext;
  logic              reqReadyNext, rspValidNext, memWriteNext;
  logic [ADDR_W-1:0] memAddressNext;
  logic [BYTE_W-1:0] memWriteValueNext;
  logic [WORD_W-1:0] rspReadDataNext;

  // State, counter and all outputs are registered from next-state values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      addrReg       <= '0;
      loByteReg     <= '0;
      reqReady      <= 1'b1;
      rspValid      <= 1'b0;
      memWrite      <= 1'b0;
      memAddress    <= '0;
      memWriteValue <= '0;
      rspReadData   <= '0;
    end else begin
      state         <= stateNext;
      cnt           <= cntNext;
      addrReg       <= addrNext;
      loByteReg     <= loByteNext;
      reqReady      <= reqReadyNext;
      rspValid      <= rspValidNext;
      memWrite      <= memWriteNext;
      memAddress    <= memAddressNext;
      memWriteValue <= memWriteValueNext;
      rspReadData   <= rspReadDataNext;
    end
  end

  always_comb begin
    stateNext         = state;
    cntNext           = cnt;
    addrNext          = addrReg;
    loByteNext        = loByteReg;
    reqReadyNext      = 1'b0;
    rspValidNext      = 1'b0;
    memWriteNext      = 1'b0;
    memAddressNext    = memAddress;
    memWriteValueNext = memWriteValue;
    rspReadDataNext   = rspReadData;

    unique case (state)
      IDLE: begin
        if (reqValid) begin
          addrNext       = reqAddress;
          loByteNext     = reqWriteData[BYTE_W-1:0];
          memAddressNext = reqAddress;
          if (reqWrite) begin
            stateNext         = WR_HI;
            memWriteNext      = 1'b1;
            memWriteValueNext = reqWriteData[WORD_W-1:BYTE_W];
          end else begin
            stateNext = RD_HI;
            cntNext   = PHASE_LOAD;
          end
        end else begin
          reqReadyNext = 1'b1;
        end
      end
      WR_HI: begin
        stateNext         = WR_LO;
        memWriteNext      = 1'b1;
        memAddressNext    = ADDR_W'(addrReg + ADDR_W'(1));
        memWriteValueNext = loByteReg;
      end
      WR_LO: begin
        stateNext    = RSP;
        rspValidNext = 1'b1;
      end
      // Each read phase holds the address until the counter expires, then
      // captures the byte on that final edge.
      RD_HI: begin
        if (cnt == '0) begin
          rspReadDataNext[WORD_W-1:BYTE_W] = memReadValue;
          stateNext      = RD_LO;
          memAddressNext = ADDR_W'(addrReg + ADDR_W'(1));
          cntNext        = PHASE_LOAD;
        end else begin
          cntNext = CNT_W'(cnt - CNT_W'(1));
        end
      end
      RD_LO: begin
        if (cnt == '0) begin
          rspReadDataNext[BYTE_W-1:0] = memReadValue;
          stateNext    = RSP;
          rspValidNext = 1'b1;
        end else begin
          cntNext = CNT_W'(cnt - CNT_W'(1));
        end
      end
      RSP: begin
        stateNext    = IDLE;
        reqReadyNext = 1'b1;
      end
      default: begin
        stateNext    = IDLE;
        reqReadyNext = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_word_adapter.sv
// Scoreboard bench for mem_word_adapter with a 64K x 8 byte memory model.
module tb_mem_word_adapter;

  localparam int unsigned RL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [15:0] reqAddress = '0;
  logic [15:0] reqWriteData = '0;
  logic        rspValid;
  logic [15:0] rspReadData;
  logic        memWrite;
  logic [15:0] memAddress;
  logic [7:0]  memWriteValue;
  logic [7:0]  memReadValue;

  mem_word_adapter #(.READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData),
    .rspValid(rspValid), .rspReadData(rspReadData),
    .memWrite(memWrite), .memAddress(memAddress),
    .memWriteValue(memWriteValue), .memReadValue(memReadValue)
  );

  always #5 clk = ~clk;

  // Byte memory: synchronous write, read data follows the address by one cycle.
  logic [7:0]  mem [0:65535];
  logic [15:0] addrDly = '0;
  always @(posedge clk) begin
    if (memWrite) mem[memAddress] <= memWriteValue;
    addrDly <= memAddress;
  end
  assign memReadValue = mem[addrDly];

  int cycCnt = 0;
  always @(posedge clk) cycCnt <= cycCnt + 1;

  typedef struct {
    bit          isRead;
    logic [15:0] data;
    int          lat;
  } exp_t;

  exp_t expQ[$];
  int   accQ[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Response monitor: pops the oldest expectation on every rspValid.
  always @(negedge clk) begin
    if (!reset && rspValid) begin
      if (expQ.size() == 0 || accQ.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int   a;
        e = expQ.pop_front();
        a = accQ.pop_front();
        chk("rsp_latency", 32'(cycCnt - a), 32'(e.lat));
        if (e.isRead) chk("rsp_data", 32'(rspReadData), 32'(e.data));
      end
    end
  end

  // Drive a request at the current negedge and wait for acceptance; reqValid stays high.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d,
                       input bit track, input logic [15:0] expData, output int accCyc);
    bit done;
    done = 1'b0;
    accCyc = -1;
    reqValid = 1'b1;
    reqWrite = wr;
    reqAddress = a;
    reqWriteData = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (reqReady) begin
        accCyc = cycCnt;
        if (track) begin
          exp_t e;
          e.isRead = !wr;
          e.data = expData;
          e.lat = wr ? 3 : 2 * (int'(RL) + 1) + 1;
          expQ.push_back(e);
          accQ.push_back(accCyc);
        end
        done = 1'b1;
        @(posedge clk);
      end
      @(negedge clk);
    end
    if (!done) chk("accept_timeout", 32'd1, 32'd0);
  endtask

  task automatic idleCycles(input int n);
    reqValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c1, c2;
    for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    mem[4] <= 8'h0E;
    mem[5] <= 8'h10;
    mem[16'h0011] <= 8'h77;

    repeat (3) @(negedge clk);
    chk("rst_reqReady", 32'(reqReady), 32'd1);
    chk("rst_rspValid", 32'(rspValid), 32'd0);
    chk("rst_memWrite", 32'(memWrite), 32'd0);
    chk("rst_memAddress", 32'(memAddress), 32'h0000);
    chk("rst_memWriteValue", 32'(memWriteValue), 32'h00);
    chk("rst_rspReadData", 32'(rspReadData), 32'h0000);
    reset = 1'b0;
    @(negedge clk);

    // Write 0x5555 @0x0000; issue returns at the cycle-1 negedge.
    issue(1'b1, 16'h0000, 16'h5555, 1'b1, 16'h0, c1);
    reqValid = 1'b0;
    chk("wr_c1_memWrite", 32'(memWrite), 32'd1);
    chk("wr_c1_addr", 32'(memAddress), 32'h0000);
    chk("wr_c1_value", 32'(memWriteValue), 32'h55);
    chk("wr_c1_reqReady", 32'(reqReady), 32'd0);
    @(negedge clk);
    chk("wr_c2_memWrite", 32'(memWrite), 32'd1);
    chk("wr_c2_addr", 32'(memAddress), 32'h0001);
    @(negedge clk);
    chk("wr_c3_memWrite", 32'(memWrite), 32'd0);
    chk("wr_c3_rspValid", 32'(rspValid), 32'd1);
    idleCycles(3);
    chk("wr_mem0", 32'(mem[0]), 32'h55);
    chk("wr_mem1", 32'(mem[1]), 32'h55);

    // Read @0x0004 expecting 0x0E10 in cycle 5, memWrite low throughout.
    issue(1'b0, 16'h0004, 16'h0, 1'b1, 16'h0E10, c1);
    reqValid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk("rd_memWrite_low", 32'(memWrite), 32'd0);
      if (k < 5) @(negedge clk);
    end
    chk("rd_c5_rspValid", 32'(rspValid), 32'd1);
    idleCycles(3);

    // Address wrap at 0xFFFF.
    issue(1'b1, 16'hFFFF, 16'hABCD, 1'b1, 16'h0, c1);
    @(negedge clk);
    chk("wrap_lo_addr", 32'(memAddress), 32'h0000);
    idleCycles(4);
    chk("wrap_memFFFF", 32'(mem[16'hFFFF]), 32'hAB);
    chk("wrap_mem0000", 32'(mem[0]), 32'hCD);
    issue(1'b0, 16'hFFFF, 16'h0, 1'b1, 16'hABCD, c1);
    idleCycles(7);

    // rspReadData survives a write.
    issue(1'b1, 16'h0040, 16'h9999, 1'b1, 16'h0, c1);
    idleCycles(5);
    chk("rdData_hold", 32'(rspReadData), 32'hABCD);

    // Reset during WR_LO abandons the write after its high byte.
    issue(1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0, c1);
    reqValid = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rstmid_memWrite", 32'(memWrite), 32'd0);
    chk("rstmid_rspValid", 32'(rspValid), 32'd0);
    chk("rstmid_reqReady", 32'(reqReady), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_reqReady_after", 32'(reqReady), 32'd1);
    idleCycles(3);
    chk("rstmid_memHi", 32'(mem[16'h0010]), 32'h12);
    chk("rstmid_memLo", 32'(mem[16'h0011]), 32'h77);

    // Back-to-back writes with reqValid held high.
    issue(1'b1, 16'h0020, 16'h1111, 1'b1, 16'h0, c1);
    reqAddress = 16'h0022;
    reqWriteData = 16'h2222;
    for (int k = 1; k <= 3; k++) begin
      chk("b2b_reqReady_low", 32'(reqReady), 32'd0);
      @(negedge clk);
    end
    issue(1'b1, 16'h0022, 16'h2222, 1'b1, 16'h0, c2);
    chk("b2b_accept_cycle", 32'(c2 - c1), 32'd4);
    idleCycles(6);
    chk("b2b_mem20", 32'(mem[16'h0020]), 32'h11);
    chk("b2b_mem23", 32'(mem[16'h0023]), 32'h22);

    chk("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
